// File: rtl/tiny16_pkg.sv
// tiny16 shared definitions: opcodes, sequencer states, mux codes, register map.
// Imported by the control unit and the register file.
package tiny16_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_LUI  = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_ADD  = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_PUSH = 4'hB;
    localparam logic [3:0] OP_POP  = 4'hC;
    localparam logic [3:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_PC  = 2'd0;
    localparam logic [1:0] ADDR_SRC = 2'd1;
    localparam logic [1:0] ADDR_DST = 2'd2;
    localparam logic [1:0] ADDR_SP  = 2'd3;

    localparam logic [1:0] IN_ALU = 2'd0;
    localparam logic [1:0] IN_MEM = 2'd1;
    localparam logic [1:0] IN_IMM = 2'd2;
    localparam logic [1:0] IN_SRC = 2'd3;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    localparam logic [3:0] REG_PC = 4'd1;
    localparam logic [3:0] REG_SP = 4'd2;
    localparam logic [3:0] REG_BP = 4'd3;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [15:0] imm;
        logic [2:0]  alu_op;
        logic        is_alu;
        logic        is_mem;
        logic        is_stack;
        logic        is_halt;
    } dec_t;

endpackage

// File: rtl/control_unit_if.sv
// Ready-handshaked memory port between the sequencer and memory.
// The write data path comes from the register file out bus, not this port.
interface control_unit_if;

    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  addr_sel;

    modport master (
        input  mem_rdata,
        input  mem_ready,
        output mem_rd,
        output mem_wr,
        output addr_sel
    );

    modport slave (
        output mem_rdata,
        output mem_ready,
        input  mem_rd,
        input  mem_wr,
        input  addr_sel
    );

endinterface

// File: rtl/control_unit_decode.sv
// Instruction decoder: splits ir into fields and instruction-class flags.
// Purely combinational.
module instr_decode
    import tiny16_pkg::*;
(
    input  logic [15:0] ir_i,
    output dec_t        dec_o
);

    logic [3:0] alu_off;

    always_comb begin
        dec_o          = '0;
        dec_o.op       = ir_i[15:12];
        dec_o.rd       = ir_i[11:8];
        dec_o.rs       = ir_i[7:4];
        dec_o.imm      = {8'h00, ir_i[7:0]};
        alu_off        = ir_i[15:12] - OP_ADD;
        dec_o.is_alu   = (ir_i[15:12] >= OP_ADD) && (ir_i[15:12] <= OP_XOR);
        dec_o.alu_op   = dec_o.is_alu ? alu_off[2:0] : ALU_ADD;
        dec_o.is_mem   = (ir_i[15:12] == OP_LD) || (ir_i[15:12] == OP_ST);
        dec_o.is_stack = (ir_i[15:12] == OP_PUSH) || (ir_i[15:12] == OP_POP);
        dec_o.is_halt  = (ir_i[15:12] == OP_HLT);
    end

endmodule

// File: rtl/control_unit.sv
// tiny16 fetch/decode/execute sequencer driving register-file strobes
// and the memory request port.
module control_unit
    import tiny16_pkg::*;
#(
    parameter logic [15:0] RESET_IR = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    control_unit_if.master mem,
    output logic [3:0]    src_sel,
    output logic [3:0]    dst_sel,
    output logic [1:0]    in_sel,
    output logic [2:0]    alu_op,
    output logic [15:0]   imm,
    output logic          in_en,
    output logic          up_en,
    output logic          lo_en,
    output logic          pc_inc,
    output logic          sp_inc,
    output logic          sp_dec,
    output logic          out_en,
    output logic [15:0]   ir,
    output logic          halted
);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    dec_t        dec;
    logic        mem_rd_c, mem_wr_c;
    logic [1:0]  addr_sel_c;

    instr_decode u_dec (
        .ir_i  (ir_q),
        .dec_o (dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            ir_q    <= RESET_IR;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        mem_rd_c   = 1'b0;
        mem_wr_c   = 1'b0;
        addr_sel_c = ADDR_PC;
        src_sel    = dec.rs;
        dst_sel    = dec.rd;
        in_sel     = IN_ALU;
        in_en      = 1'b0;
        up_en      = 1'b0;
        lo_en      = 1'b0;
        pc_inc     = 1'b0;
        sp_inc     = 1'b0;
        sp_dec     = 1'b0;
        out_en     = 1'b0;

        unique case (state_q)
            FETCH: begin
                src_sel  = 4'd0;
                dst_sel  = 4'd0;
                mem_rd_c = 1'b1;
                if (mem.mem_ready) begin
                    ir_d    = mem.mem_rdata;
                    pc_inc  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                unique case (1'b1)
                    dec.op == OP_MOV: begin
                        in_en  = 1'b1;
                        in_sel = IN_SRC;
                    end
                    dec.op == OP_LDI: begin
                        lo_en  = 1'b1;
                        in_sel = IN_IMM;
                    end
                    dec.op == OP_LUI: begin
                        up_en  = 1'b1;
                        in_sel = IN_IMM;
                    end
                    dec.is_alu:         in_en  = 1'b1;
                    dec.op == OP_PUSH:  sp_dec = 1'b1;
                    default: ;
                endcase
                if (dec.is_mem || dec.is_stack) state_d = MEM;
                if (dec.is_halt)                state_d = HALT;
            end
            MEM: begin
                unique case (dec.op)
                    OP_LD: begin
                        mem_rd_c   = 1'b1;
                        addr_sel_c = ADDR_SRC;
                        in_sel     = IN_MEM;
                        in_en      = mem.mem_ready;
                    end
                    OP_ST: begin
                        mem_wr_c   = 1'b1;
                        addr_sel_c = ADDR_DST;
                        out_en     = 1'b1;
                    end
                    OP_PUSH: begin
                        mem_wr_c   = 1'b1;
                        addr_sel_c = ADDR_SP;
                        out_en     = 1'b1;
                    end
                    OP_POP: begin
                        mem_rd_c   = 1'b1;
                        addr_sel_c = ADDR_SP;
                        in_sel     = IN_MEM;
                        in_en      = mem.mem_ready;
                        // POP into SP takes the loaded value as the new SP
                        sp_inc     = mem.mem_ready && (dec.rd != REG_SP);
                    end
                    default: ;
                endcase
                if (mem.mem_ready) state_d = FETCH;
            end
            HALT: ;
            default: state_d = FETCH;
        endcase

        if (rst) begin
            mem_rd_c = 1'b0;
            mem_wr_c = 1'b0;
            in_en    = 1'b0;
            up_en    = 1'b0;
            lo_en    = 1'b0;
            pc_inc   = 1'b0;
            sp_inc   = 1'b0;
            sp_dec   = 1'b0;
            out_en   = 1'b0;
        end
    end

    assign mem.mem_rd   = mem_rd_c;
    assign mem.mem_wr   = mem_wr_c;
    assign mem.addr_sel = addr_sel_c;
    assign alu_op       = dec.alu_op;
    assign imm          = dec.imm;
    assign ir           = ir_q;
    assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed sequences plus randomized
// instruction streams with random memory wait states.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src_sel, dst_sel;
    logic [1:0]  in_sel;
    logic [2:0]  alu_op;
    logic [15:0] imm, ir;
    logic        in_en, up_en, lo_en, pc_inc;
    logic        sp_inc, sp_dec, out_en, halted;

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] cur_ir;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [1:0]  as;
        logic [3:0]  ss;
        logic [3:0]  ds;
        logic [1:0]  isel;
        logic [2:0]  ao;
        logic [15:0] im;
        logic        ie, ue, le, pi, si, sd, oe, h;
        logic [15:0] irv;
    } exp_t;

    always #5 clk = ~clk;

    control_unit_if mem_bus ();

    control_unit #(.RESET_IR(16'h0000)) dut (
        .clk     (clk),
        .rst     (rst),
        .mem     (mem_bus),
        .src_sel (src_sel),
        .dst_sel (dst_sel),
        .in_sel  (in_sel),
        .alu_op  (alu_op),
        .imm     (imm),
        .in_en   (in_en),
        .up_en   (up_en),
        .lo_en   (lo_en),
        .pc_inc  (pc_inc),
        .sp_inc  (sp_inc),
        .sp_dec  (sp_dec),
        .out_en  (out_en),
        .ir      (ir),
        .halted  (halted)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic bit is_mem_op(input logic [3:0] op);
        return op == 4'h4 || op == 4'h5 || op == 4'hB || op == 4'hC;
    endfunction

    // Fields that follow directly from the held instruction in any state
    function automatic exp_t base(input logic [15:0] i);
        exp_t e = '0;
        int   op = int'(i[15:12]);
        e.ds  = i[11:8];
        e.ss  = i[7:4];
        e.im  = {8'h00, i[7:0]};
        e.ao  = (op >= 6 && op <= 10) ? 3'(op - 6) : 3'd0;
        e.irv = i;
        return e;
    endfunction

    task automatic cyc(input string tag, input logic rdy,
                       input logic [15:0] rdata, input exp_t e);
        exp_t a;
        mem_bus.mem_ready = rdy;
        mem_bus.mem_rdata = rdata;
        @(negedge clk);
        a = '{rd: mem_bus.mem_rd, wr: mem_bus.mem_wr, as: mem_bus.addr_sel,
              ss: src_sel, ds: dst_sel, isel: in_sel, ao: alu_op, im: imm,
              ie: in_en, ue: up_en, le: lo_en, pi: pc_inc, si: sp_inc,
              sd: sp_dec, oe: out_en, h: halted, irv: ir};
        check(tag, 64'(a), 64'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 16'($urandom);
        @(negedge clk);
        check("rst_strobes", 64'({mem_bus.mem_rd, mem_bus.mem_wr, in_en,
              up_en, lo_en, pc_inc, sp_inc, sp_dec, out_en}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur_ir = 16'h0000;
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_ir", 64'(ir), 64'd0);
    endtask

    task automatic do_fetch(input logic [15:0] instr, input int waits);
        exp_t e;
        for (int w = 0; w <= waits; w++) begin
            e    = base(cur_ir);
            e.ss = 4'd0;
            e.ds = 4'd0;
            e.rd = 1'b1;
            e.pi = (w == waits);
            cyc("fetch", w == waits, (w == waits) ? instr : 16'($urandom), e);
        end
        cur_ir = instr;
    endtask

    task automatic do_exec();
        exp_t e  = base(cur_ir);
        int   op = int'(cur_ir[15:12]);
        if (op == 1) begin e.ie = 1'b1; e.isel = 2'd3; end
        if (op == 2) begin e.le = 1'b1; e.isel = 2'd2; end
        if (op == 3) begin e.ue = 1'b1; e.isel = 2'd2; end
        if (op >= 6 && op <= 10) e.ie = 1'b1;
        if (op == 11) e.sd = 1'b1;
        cyc("exec", 1'($urandom), 16'($urandom), e);
    endtask

    task automatic do_mem(input int waits);
        exp_t e;
        logic r;
        for (int w = 0; w <= waits; w++) begin
            r = (w == waits);
            e = base(cur_ir);
            case (cur_ir[15:12])
                4'h4: begin e.rd = 1; e.as = 2'd1; e.isel = 2'd1; e.ie = r; end
                4'h5: begin e.wr = 1; e.as = 2'd2; e.oe = 1; end
                4'hB: begin e.wr = 1; e.as = 2'd3; e.oe = 1; end
                4'hC: begin
                    e.rd = 1; e.as = 2'd3; e.isel = 2'd1; e.ie = r;
                    e.si = r && (cur_ir[11:8] != 4'd2);
                end
                default: ;
            endcase
            cyc("mem", r, 16'($urandom), e);
        end
    endtask

    task automatic run(input logic [15:0] instr, input int fw, input int mw);
        do_fetch(instr, fw);
        do_exec();
        if (is_mem_op(instr[15:12])) do_mem(mw);
    endtask

    initial begin
        exp_t        e;
        logic [15:0] instr;
        rst = 1'b1;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        run(16'h2A5C, 0, 0);
        run(16'h3112, 3, 0);
        run(16'hB050, 0, 2);
        run(16'hC700, 0, 1);
        run(16'hC200, 1, 0);
        run(16'h1140, 0, 0);
        run(16'h4230, 2, 3);
        run(16'h5450, 0, 0);
        run(16'h7ABC, 1, 0);
        run(16'hD123, 0, 0);

        // reset while a PUSH is waiting in its memory phase
        do_fetch(16'hB090, 0);
        do_exec();
        do_reset();
        run(16'h0000, 1, 0);

        for (int k = 0; k < 300; k++) begin
            instr = {4'($urandom_range(0, 14)), 12'($urandom)};
            run(instr, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        run(16'hF000, 0, 0);
        for (int k = 0; k < 10; k++) begin
            e   = base(cur_ir);
            e.h = 1'b1;
            cyc("halt", 1'($urandom), 16'($urandom), e);
        end
        do_reset();
        run(16'h2A5C, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Fetch/decode/execute sequencer for the tiny16 core. It sits directly upstream of the register file and drives that file's select, write-enable and pointer-update strobes. It fetches 16-bit instructions at PC over a ready-handshaked memory port, latches them in an instruction register, and sequences single-cycle register/ALU ops and multi-cycle memory and stack ops.

Parameters:
RESET_IR, 16'h0000, instruction-register value after reset (decodes as NOP).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
mem_rdata  in  16  memory read data, valid when mem_ready=1
mem_ready  in  1  memory completes the current mem_rd/mem_wr this cycle
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request; write data is the register file's out bus
addr_sel  out  2  address mux select: 0=PC, 1=src reg, 2=dst reg, 3=SP
src_sel  out  4  register file source index
dst_sel  out  4  register file destination index
in_sel  out  2  register-file input mux select: 0=ALU, 1=mem_rdata, 2=imm, 3=src reg
alu_op  out  3  0=ADD, 1=SUB, 2=AND, 3=OR, 4=XOR
imm  out  16  zero-extended ir[7:0]
in_en, up_en, lo_en  out  1 each  register file full, upper-byte and lower-byte write strobes
pc_inc, sp_inc, sp_dec, out_en  out  1 each  register file strobes
ir  out  16  current instruction register
halted  out  1  core is in HALT

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. On reset: state=FETCH, ir=RESET_IR, halted=0.
- All strobes are 0 during any cycle in which rst=1. Strobes are combinational from state, ir and mem_ready.
- Instruction fields: op=ir[15:12], rd=ir[11:8], rs=ir[7:4], imm8=ir[7:0]. dst_sel=rd and src_sel=rs in every state except FETCH, where both are 0.
- Opcodes:
  - 0 NOP
  - 1 MOV rd,rs
  - 2 LDI: lo_en, in_sel=imm
  - 3 LUI: up_en, in_sel=imm
  - 4 LD rd,[rs]
  - 5 ST [rd],rs
  - 6-A: ALU ops, with alu_op=op-6
  - B PUSH rs
  - C POP rd
  - D, E: reserved, executed as NOP
  - F HLT
- State FETCH:
  - Assert mem_rd and addr_sel=PC.
  - Hold both stable until mem_ready=1.
  - In the mem_ready cycle: ir<=mem_rdata, pc_inc=1, next state EXEC.
  - No other strobe is active in FETCH.
- State EXEC (exactly 1 cycle):
  - MOV: in_en, in_sel=3.
  - LDI/LUI: as listed in the opcode table.
  - ALU ops: in_en, in_sel=0.
  - Each of the above returns to FETCH.
  - PUSH: sp_dec=1, then MEM.
  - LD, ST, POP: no strobes, then MEM.
  - NOP/reserved: no strobes, then FETCH.
  - HLT: next state HALT.
- State MEM: hold request and address until mem_ready=1, then return to FETCH. Per opcode:
  - LD: mem_rd, addr_sel=1. In the ready cycle: in_en, in_sel=1.
  - ST: mem_wr, addr_sel=2, out_en.
  - PUSH: mem_wr, addr_sel=3, out_en. Pre-decrement: the write lands at the new SP.
  - POP: mem_rd, addr_sel=3. In the ready cycle: in_en, in_sel=1 and sp_inc=1. Exception: POP with rd=2 loads SP from memory and suppresses sp_inc.
- State HALT: halted=1, all strobes 0. The core leaves HALT only on rst.
- Invariants:
  - pc_inc is never asserted in a cycle that writes PC (PC is register 1).
  - sp_inc and sp_dec are never asserted together.
  - mem_rd and mem_wr are mutually exclusive.
  - Writes with rd=0 may assert enables; the register file ignores them.
- Latency:
  - Register/ALU/immediate ops: FETCH wait + 1 cycle.
  - Memory and stack ops: FETCH wait + 1 + MEM wait.
- Reset mid-transaction: any outstanding request is dropped at the next edge. Memory must tolerate a dropped request.

Decomposition:
- Package tiny16_pkg holds:
  - opcode constants;
  - state encoding (FETCH, EXEC, MEM, HALT);
  - addr_sel, in_sel and alu_op codes;
  - register indices PC=1, SP=2, BP=3, shared with the register file.
- Sub-module instr_decode: combinational; maps ir to field values and instruction-class flags (is_alu, is_mem, is_stack, is_halt).

Test Plan:
- Reset then mem_ready=1 with mem_rdata=16'h2A5C (LDI r10):
  - cycle 1: mem_rd=1, addr_sel=0, pc_inc=1;
  - cycle 2: dst_sel=4'hA, lo_en=1, in_sel=2, imm=16'h005C;
  - cycle 3: back in FETCH.
- Fetch with mem_ready low for 3 cycles: mem_rd and addr_sel held for 4 cycles; pc_inc asserted only in the 4th; ir unchanged until then.
- PUSH r5 (16'hB050), MEM ready after 2 waits:
  - EXEC: sp_dec=1 once;
  - MEM: mem_wr=1, addr_sel=3, src_sel=5, out_en=1 for 3 cycles;
  - no second sp_dec.
- POP r7 (16'hC700): MEM ready cycle has in_en=1, in_sel=1, dst_sel=7, sp_inc=1. POP r2 (16'hC200): same, except sp_inc=0.
- MOV r1,r4 (16'h1140): EXEC has in_en=1, dst_sel=1, src_sel=4, in_sel=3, pc_inc=0. The next FETCH uses the new PC.
- HLT (16'hF000): halted=1 and no mem_rd for 10 cycles. Then rst for 1 cycle: halted=0, and mem_rd=1 in FETCH on the cycle after rst deasserts.
